fir_alu_sequencer: RTL and testbench

- Initiator/controller for the shared two-function `alu` (SELECT=0 multiply, SELECT=1 add, registered result on ANS).
- Accepts one input sample per handshake and shifts it into a TAPS-deep delay line.
- Computes y = sum(coef[k] * x[n-k]) by issuing alternating multiply/add operations to the external ALU, then presents y with a valid/ready handshake.
- Sits between the sample source and the FIR output stage; it is the datapath driver the ALU bench currently emulates.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_alu_sequencer_if.sv | 39 +++
 rtl/fir_delay_line.sv | 29 ++
 rtl/fir_alu_sequencer.sv | 159 +++++++++++++++
 tb/tb_fir_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR/ALU sequencer slice.
// Holds ALU opcodes, default widths, FSM states and a clog2 helper.
package fir_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ALU_W_DEF  = 38;

   localparam logic ALU_OP_MUL = 1'b0;
   localparam logic ALU_OP_ADD = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_ADD_ISSUE,
      S_ADD_WAIT,
      S_DONE
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fir_alu_sequencer_if.sv
// Sample, coefficient, ALU and output bus of the FIR sequencer.
// master = sequencer side, slave = source/ALU/sink side.
interface fir_alu_sequencer_if
   import fir_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ALU_W  = ALU_W_DEF,
   parameter int AW     = 2
);
   logic [DATA_W-1:0] X_IN;
   logic              X_VALID;
   logic              X_READY;
   logic              COEF_WE;
   logic [AW-1:0]     COEF_ADDR;
   logic [DATA_W-1:0] COEF_DATA;
   logic [ALU_W-1:0]  ALU_A;
   logic [ALU_W-1:0]  ALU_B;
   logic              ALU_SELECT;
   logic [ALU_W-1:0]  ALU_ANS;
   logic [ALU_W-1:0]  Y_OUT;
   logic              Y_VALID;
   logic              Y_READY;
   logic              OVF;

   modport master (
      input  X_IN, X_VALID, COEF_WE, COEF_ADDR, COEF_DATA,
      input  ALU_ANS, Y_READY,
      output X_READY, ALU_A, ALU_B, ALU_SELECT,
      output Y_OUT, Y_VALID, OVF
   );

   modport slave (
      output X_IN, X_VALID, COEF_WE, COEF_ADDR, COEF_DATA,
      output ALU_ANS, Y_READY,
      input  X_READY, ALU_A, ALU_B, ALU_SELECT,
      input  Y_OUT, Y_VALID, OVF
   );

endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register with indexed read port.
// x[0] is the newest sample.
module fir_delay_line #(
   parameter int TAPS   = 4,
   parameter int DATA_W = 16,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   input  logic [AW-1:0]     rd_idx,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] x_q [TAPS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      end else if (shift_en) begin
         x_q[0] <= din;
         for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
   end

   assign dout = x_q[rd_idx];

endmodule

// File: rtl/fir_alu_sequencer.sv
// FIR controller driving a shared multiply/add ALU, one tap per MAC pair.
// Define FIR_SEQ_OVF_EN to enable the sticky accumulate-overflow flag.
module fir_alu_sequencer
   import fir_pkg::*;
#(
   parameter int TAPS    = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ALU_W   = ALU_W_DEF,
   parameter int ALU_LAT = 1
) (
   input logic CLK,
   input logic RESETN,
   fir_alu_sequencer_if.master bus
);

   localparam int AW   = clog2(TAPS);
   localparam int PADW = ALU_W - DATA_W;
   localparam logic [1:0]    W_LAST = 2'(ALU_LAT - 1);
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

   state_e state_q, state_d;

   logic [DATA_W-1:0] coef_q [TAPS];
   logic [DATA_W-1:0] x_cap_q;
   logic [DATA_W-1:0] x_rd;
   logic [AW-1:0]     k_q;
   logic [1:0]        wcnt_q;
   logic [ALU_W-1:0]  acc_q;
   logic [ALU_W-1:0]  prod_q;
   logic [ALU_W-1:0]  y_out_q;
   logic              y_valid_q;

   logic             accept;
   logic             last_wait;
   logic [ALU_W-1:0] alu_a;
   logic [ALU_W-1:0] alu_b;
   logic             alu_sel;

   assign bus.X_READY = (state_q == S_IDLE) && RESETN;
   assign accept      = bus.X_VALID && bus.X_READY;
   assign last_wait   = (wcnt_q == W_LAST);

   fir_delay_line #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_dly (
      .clk      (CLK),
      .rst_n    (RESETN),
      .shift_en (state_q == S_SHIFT),
      .din      (x_cap_q),
      .rd_idx   (k_q),
      .dout     (x_rd)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = ALU_OP_MUL;
      unique case (state_q)
         S_IDLE:      if (accept) state_d = S_SHIFT;
         S_SHIFT:     state_d = S_MUL_ISSUE;
         S_MUL_ISSUE,
         S_MUL_WAIT: begin
            alu_a = {{PADW{1'b0}}, coef_q[k_q]};
            alu_b = {{PADW{1'b0}}, x_rd};
            if (state_q == S_MUL_ISSUE) state_d = S_MUL_WAIT;
            else if (last_wait)         state_d = S_ADD_ISSUE;
         end
         S_ADD_ISSUE,
         S_ADD_WAIT: begin
            alu_a   = acc_q;
            alu_b   = prod_q;
            alu_sel = ALU_OP_ADD;
            if (state_q == S_ADD_ISSUE) state_d = S_ADD_WAIT;
            else if (last_wait)
               state_d = (k_q == K_LAST) ? S_DONE : S_MUL_ISSUE;
         end
         S_DONE:      if (y_valid_q && bus.Y_READY) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   assign bus.ALU_A      = alu_a;
   assign bus.ALU_B      = alu_b;
   assign bus.ALU_SELECT = alu_sel;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
         x_cap_q   <= '0;
         k_q       <= '0;
         wcnt_q    <= '0;
         acc_q     <= '0;
         prod_q    <= '0;
         y_out_q   <= '0;
         y_valid_q <= 1'b0;
      end else begin
         if (accept) x_cap_q <= bus.X_IN;
         if (state_q == S_IDLE && bus.COEF_WE && int'(bus.COEF_ADDR) < TAPS)
            coef_q[bus.COEF_ADDR] <= bus.COEF_DATA;
         unique case (state_q)
            S_SHIFT: begin
               acc_q  <= '0;
               k_q    <= '0;
               wcnt_q <= '0;
            end
            S_MUL_WAIT: begin
               wcnt_q <= last_wait ? 2'd0 : wcnt_q + 2'd1;
               if (last_wait) prod_q <= bus.ALU_ANS;
            end
            S_ADD_WAIT: begin
               wcnt_q <= last_wait ? 2'd0 : wcnt_q + 2'd1;
               if (last_wait) begin
                  acc_q <= bus.ALU_ANS;
                  if (k_q != K_LAST) k_q <= k_q + 1'b1;
               end
            end
            // Y_OUT is registered one cycle into DONE and frozen until taken.
            S_DONE: begin
               if (!y_valid_q) begin
                  y_valid_q <= 1'b1;
                  y_out_q   <= acc_q;
               end else if (bus.Y_READY) begin
                  y_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Y_OUT   = y_out_q;
   assign bus.Y_VALID = y_valid_q;

`ifdef FIR_SEQ_OVF_EN
   logic ovf_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN)
         ovf_q <= 1'b0;
      else if (accept)
         ovf_q <= 1'b0;
      else if (state_q == S_ADD_WAIT && last_wait && bus.ALU_ANS < acc_q)
         ovf_q <= 1'b1;
   end

   assign bus.OVF = ovf_q;
`else
   assign bus.OVF = 1'b0;
`endif

endmodule

// File: tb/tb_fir_alu_sequencer.sv
// Directed bench for fir_alu_sequencer with a registered model ALU.
// Build with FIR_SEQ_OVF_EN to also exercise the overflow flag.
module tb_fir_alu_sequencer;
   import fir_pkg::*;

   localparam int LAT = 18;
   localparam logic [37:0] P = 38'd4294836225;

   logic clk = 1'b0;
   logic rst_n;
   logic force_arm;
   logic forced;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fir_alu_sequencer_if #(.DATA_W(16), .ALU_W(38), .AW(2)) bus ();

   fir_alu_sequencer #(
      .TAPS    (4),
      .DATA_W  (16),
      .ALU_W   (38),
      .ALU_LAT (1)
   ) dut (
      .CLK    (clk),
      .RESETN (rst_n),
      .bus    (bus)
   );

   // Model ALU: one-cycle registered result; can corrupt one non-zero add.
   always @(posedge clk) begin
      if (!rst_n) forced <= 1'b0;
      if (bus.ALU_SELECT) begin
         if (force_arm && !forced && bus.ALU_A != '0) begin
            bus.ALU_ANS <= bus.ALU_A - 38'd1;
            forced      <= 1'b1;
         end else begin
            bus.ALU_ANS <= bus.ALU_A + bus.ALU_B;
         end
      end else begin
         bus.ALU_ANS <= bus.ALU_A * bus.ALU_B;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic write_coef(input int a, input int d);
      @(negedge clk);
      bus.COEF_WE   = 1'b1;
      bus.COEF_ADDR = 2'(a);
      bus.COEF_DATA = 16'(d);
      @(negedge clk);
      bus.COEF_WE = 1'b0;
   endtask

   task automatic accept(input logic [15:0] x);
      @(negedge clk);
      bus.X_IN    = x;
      bus.X_VALID = 1'b1;
      for (int i = 0; i < 60 && !bus.X_READY; i++) @(negedge clk);
      if (!bus.X_READY) check("accept_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      bus.X_VALID = 1'b0;
   endtask

   // Counts edges until Y_VALID; called at #1 after the accept edge.
   task automatic wait_y(output int n, output bit rdy_seen,
                         input bit mid_we);
      n = 0;
      rdy_seen = 1'b0;
      while (!bus.Y_VALID && n < 60) begin
         if (bus.X_READY) rdy_seen = 1'b1;
         if (mid_we && n == 4) begin
            bus.COEF_WE   = 1'b1;
            bus.COEF_ADDR = 2'd0;
            bus.COEF_DATA = 16'd9;
         end
         @(posedge clk);
         #1;
         bus.COEF_WE = 1'b0;
         n++;
      end
   endtask

   task automatic run_sample(input logic [15:0] x, input logic [37:0] exp,
                             input string tag, input bit mid_we,
                             input bit chk_y);
      int n;
      bit rs;
      accept(x);
      check({tag, "_ovf_clr"}, 64'(bus.OVF), 64'(0));
      wait_y(n, rs, mid_we);
      check({tag, "_lat"}, 64'(n), 64'(LAT));
      check({tag, "_xrdy"}, 64'(rs), 64'(0));
      if (chk_y) check({tag, "_y"}, 64'(bus.Y_OUT), 64'(exp));
      @(posedge clk);
      #1;
      check({tag, "_ydrop"}, 64'(bus.Y_VALID), 64'(0));
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : main
      int n;
      bit rs;
      bit stable;
      logic [37:0] imp_exp [5];
      logic [37:0] step_exp [6];
      imp_exp  = '{38'd1, 38'd2, 38'd3, 38'd4, 38'd0};
      step_exp = '{38'd5, 38'd10, 38'd15, 38'd20, 38'd20, 38'd20};

      rst_n         = 1'b0;
      force_arm     = 1'b0;
      bus.X_IN      = '0;
      bus.X_VALID   = 1'b0;
      bus.COEF_WE   = 1'b0;
      bus.COEF_ADDR = '0;
      bus.COEF_DATA = '0;
      bus.Y_READY   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_xrdy", 64'(bus.X_READY), 64'(0));
      check("rst_yv", 64'(bus.Y_VALID), 64'(0));
      check("rst_y", 64'(bus.Y_OUT), 64'(0));
      check("rst_a", 64'(bus.ALU_A), 64'(0));
      check("rst_b", 64'(bus.ALU_B), 64'(0));
      check("rst_sel", 64'(bus.ALU_SELECT), 64'(0));
      check("rst_ovf", 64'(bus.OVF), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while waiting on the first multiply.
      for (int i = 0; i < 4; i++) write_coef(i, i + 1);
      accept(16'd7);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("mw_a", 64'(bus.ALU_A), 64'(1));
      check("mw_b", 64'(bus.ALU_B), 64'(7));
      check("mw_sel", 64'(bus.ALU_SELECT), 64'(0));
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mr_a", 64'(bus.ALU_A), 64'(0));
      check("mr_b", 64'(bus.ALU_B), 64'(0));
      check("mr_xrdy", 64'(bus.X_READY), 64'(0));
      check("mr_yv", 64'(bus.Y_VALID), 64'(0));
      rst_n = 1'b1;
      rs = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.Y_VALID) rs = 1'b1;
      end
      check("mr_no_y", 64'(rs), 64'(0));
      run_sample(16'd1, 38'd0, "post_rst", 1'b0, 1'b1);
      reset_pulse();

      // Impulse response.
      for (int i = 0; i < 4; i++) write_coef(i, i + 1);
      run_sample(16'd1, imp_exp[0], "imp0", 1'b0, 1'b1);
      for (int i = 1; i < 5; i++)
         run_sample(16'd0, imp_exp[i], $sformatf("imp%0d", i), 1'b0, 1'b1);

      // Step response.
      for (int i = 0; i < 4; i++) write_coef(i, 1);
      for (int i = 0; i < 6; i++)
         run_sample(16'd5, step_exp[i], $sformatf("step%0d", i), 1'b0, 1'b1);

      // Output stall with a sample waiting.
      @(negedge clk);
      bus.Y_READY = 1'b0;
      accept(16'd3);
      wait_y(n, rs, 1'b0);
      check("stall_lat", 64'(n), 64'(LAT));
      check("stall_y", 64'(bus.Y_OUT), 64'(18));
      bus.X_IN    = 16'd4;
      bus.X_VALID = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!bus.Y_VALID || bus.Y_OUT != 38'd18 || bus.X_READY)
            stable = 1'b0;
      end
      check("stall_stable", 64'(stable), 64'(1));
      @(negedge clk);
      bus.Y_READY = 1'b1;
      @(posedge clk);
      #1;
      check("hs_yv", 64'(bus.Y_VALID), 64'(0));
      check("hs_idle", 64'(bus.X_READY), 64'(1));
      @(posedge clk);
      #1;
      bus.X_VALID = 1'b0;
      check("hs_acc", 64'(bus.X_READY), 64'(0));
      wait_y(n, rs, 1'b0);
      check("held_lat", 64'(n), 64'(LAT));
      check("held_y", 64'(bus.Y_OUT), 64'(17));
      @(posedge clk);
      #1;

      // Coefficient write: ignored while busy, applied in IDLE.
      run_sample(16'd2, 38'd14, "we_busy", 1'b1, 1'b1);
      write_coef(0, 9);
      run_sample(16'd0, 38'd9, "we_idle", 1'b0, 1'b1);

`ifdef FIR_SEQ_OVF_EN
      reset_pulse();
      for (int i = 0; i < 4; i++) write_coef(i, 65535);
      for (int i = 0; i < 4; i++) begin
         run_sample(16'hFFFF, P * 38'(i + 1), $sformatf("big%0d", i),
                    1'b0, 1'b1);
         check($sformatf("big%0d_ovf", i), 64'(bus.OVF), 64'(0));
      end
      force_arm = 1'b1;
      run_sample(16'hFFFF, 38'd0, "frc", 1'b0, 1'b0);
      check("frc_ovf", 64'(bus.OVF), 64'(1));
      repeat (5) @(posedge clk);
      #1;
      check("frc_sticky", 64'(bus.OVF), 64'(1));
      run_sample(16'd0, P * 38'd3, "after_frc", 1'b0, 1'b1);
`else
      check("ovf_tied", 64'(bus.OVF), 64'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
